// File: rtl/ic_gate_tester_param.sv
// Exhaustive tester for multi-gate logic ICs (NUM_GATES identical gates of
// GATE_INPUTS inputs each). Every input combination is driven to all gates at
// once and held for SETTLE_CYCLES. The synchronised gate outputs are then
// compared against the gate function selected by mode. Per-gate failures are
// sticky and are reported when the test finishes.
module ic_gate_tester_param #(
  parameter int NUM_GATES     = 4,
  parameter int GATE_INPUTS   = 2,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             start_i,
  input  logic [2:0]                       mode_i,
  output logic [NUM_GATES*GATE_INPUTS-1:0] dut_in_o,
  input  logic [NUM_GATES-1:0]             dut_out_i,
  output logic [NUM_GATES-1:0]             gate_pass_o,
  output logic [NUM_GATES-1:0]             gate_fail_o,
  output logic                             pass_o,
  output logic                             fail_o,
  output logic                             busy_o,
  output logic                             done_o
);

  localparam int NUM_VECS = 1 << GATE_INPUTS;
  localparam int VW       = GATE_INPUTS + 1;
  localparam int CW       = $clog2(SETTLE_CYCLES + 1);

  localparam logic [VW-1:0] LAST_VEC    = VW'(NUM_VECS - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_e;

  state_e                           state_q;
  logic [VW-1:0]                    vec_q;
  logic [VW-1:0]                    vec_d;
  logic [CW-1:0]                    settleCnt_q;
  logic [2:0]                       mode_q;
  logic [NUM_GATES-1:0]             failFlag_q;
  logic [NUM_GATES-1:0]             failFlag_d;
  logic [NUM_GATES-1:0]             sync1_q;
  logic [NUM_GATES-1:0]             sync2_q;
  logic [NUM_GATES*GATE_INPUTS-1:0] dutIn_q;
  logic [NUM_GATES*GATE_INPUTS-1:0] dutIn_d;
  logic                             busy_q;
  logic                             done_q;
  logic [NUM_GATES-1:0]             gatePass_q;
  logic [NUM_GATES-1:0]             gateFail_q;
  logic                             pass_q;
  logic                             fail_q;
  logic [GATE_INPUTS-1:0]           vecBits;
  logic                             expectedBit;

  // Two-flop synchroniser for the asynchronous gate outputs of the IC.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= dut_out_i;
      sync2_q <= sync1_q;
    end
  end

  // Expected gate response for the current vector, the updated fail flags and the next vector pattern.
  always_comb begin
    vecBits     = vec_q[GATE_INPUTS-1:0];
    expectedBit = 1'b0;
    case (mode_q)
      3'd0:    expectedBit = &vecBits;
      3'd1:    expectedBit = |vecBits;
      3'd2:    expectedBit = ~&vecBits;
      3'd3:    expectedBit = ~|vecBits;
      3'd4:    expectedBit = ^vecBits;
      3'd5:    expectedBit = ~^vecBits;
      default: expectedBit = 1'b0;
    endcase
    failFlag_d = failFlag_q | (sync2_q ^ {NUM_GATES{expectedBit}});
    vec_d      = vec_q + VW'(1);
    dutIn_d    = {NUM_GATES{vec_d[GATE_INPUTS-1:0]}};
  end

  // Test sequencer: walks every vector through settle and sample, driving the IC pins as it goes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      vec_q       <= '0;
      settleCnt_q <= '0;
      mode_q      <= '0;
      failFlag_q  <= '0;
      dutIn_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            mode_q      <= mode_i;
            vec_q       <= '0;
            settleCnt_q <= '0;
            dutIn_q     <= '0;
            if (mode_i > 3'd5) begin
              failFlag_q <= '1;
              busy_q     <= 1'b0;
              state_q    <= S_DONE;
            end else begin
              failFlag_q <= '0;
              busy_q     <= 1'b1;
              state_q    <= S_SETTLE;
            end
          end
        end
        S_SETTLE: begin
          if (settleCnt_q == SETTLE_LAST) begin
            settleCnt_q <= '0;
            state_q     <= S_SAMPLE;
          end else begin
            settleCnt_q <= settleCnt_q + CW'(1);
          end
        end
        S_SAMPLE: begin
          failFlag_q <= failFlag_d;
          if (vec_q == LAST_VEC) begin
            dutIn_q <= '0;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end else begin
            vec_q   <= vec_d;
            dutIn_q <= dutIn_d;
            state_q <= S_SETTLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Result register: publishes the fail flags once the sequencer has finished, cleared by a new start.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      done_q     <= 1'b0;
      gatePass_q <= '0;
      gateFail_q <= '0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
    end else if ((state_q == S_DONE) && !start_i) begin
      done_q     <= 1'b1;
      gatePass_q <= ~failFlag_q;
      gateFail_q <= failFlag_q;
      pass_q     <= ~|failFlag_q;
      fail_q     <= |failFlag_q;
    end else begin
      done_q     <= 1'b0;
      gatePass_q <= '0;
      gateFail_q <= '0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
    end
  end

  assign dut_in_o    = dutIn_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign gate_pass_o = gatePass_q;
  assign gate_fail_o = gateFail_q;
  assign pass_o      = pass_q;
  assign fail_o      = fail_q;

endmodule
